// File: rtl/dpram_uart_tx_sched_if.sv
// Bus bundle between the transmit scheduler, the dual-port RAM read port and the UART transmitter.
// master: scheduler side; slave: RAM/transmitter/requester side.
interface dpram_uart_tx_sched_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned LW = 9
) ();

  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] byte_len;
  logic [AW-1:0] ram_rdaddr;
  logic [7:0]    ram_q;
  logic [7:0]    data_byte;
  logic          send_en;
  logic          tx_done;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start,
    input  start_addr,
    input  byte_len,
    input  ram_q,
    input  tx_done,
    output ram_rdaddr,
    output data_byte,
    output send_en,
    output busy,
    output done,
    output err
  );

  modport slave (
    output start,
    output start_addr,
    output byte_len,
    output ram_q,
    output tx_done,
    input  ram_rdaddr,
    input  data_byte,
    input  send_en,
    input  busy,
    input  done,
    input  err
  );

endinterface

// File: rtl/dpram_uart_tx_sched.sv
// Transmit scheduler: streams byte_len RAM bytes to a byte-wide UART, one tx_done per byte.
// Optional feature macro SUM_BYTE_EN appends an 8-bit checksum byte after the payload.
module dpram_uart_tx_sched #(
  parameter int unsigned AW      = 8,
  parameter int unsigned LW      = 9,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 65535
) (
  input logic                   clk,
  input logic                   rst,
  dpram_uart_tx_sched_if.master bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRd    = 3'd1;
  localparam logic [2:0] StWaitq = 3'd2;
  localparam logic [2:0] StSend  = 3'd3;
  localparam logic [2:0] StWaitd = 3'd4;
  localparam logic [2:0] StFin   = 3'd5;

  localparam logic [1:0]  LatInit = 2'(RD_LAT - 1);
  localparam logic [16:0] TmoLast = 17'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [1:0]    lat_q, lat_d;
  logic [16:0]   tmo_q, tmo_d;
  logic [7:0]    sum_q, sum_d;
  logic [AW-1:0] rdaddr_q, rdaddr_d;
  logic [7:0]    data_q, data_d;
  logic          send_en_q, send_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef SUM_BYTE_EN
  logic          sum_phase_q, sum_phase_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    lat_d     = lat_q;
    tmo_d     = tmo_q;
    sum_d     = sum_q;
    rdaddr_d  = rdaddr_q;
    data_d    = data_q;
    send_en_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    // busy stays up through the done/err pulse cycle, so a start there is refused.
    busy_d    = busy_q && !(done_q || err_q);
`ifdef SUM_BYTE_EN
    sum_phase_d = sum_phase_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.start && !busy_q) begin
          addr_d = bus.start_addr;
          rem_d  = bus.byte_len;
          sum_d  = 8'h00;
          tmo_d  = '0;
          busy_d = 1'b1;
`ifdef SUM_BYTE_EN
          sum_phase_d = 1'b0;
`endif
          if (bus.byte_len == '0) begin
`ifdef SUM_BYTE_EN
            data_d      = 8'h00;
            sum_phase_d = 1'b1;
            send_en_d   = 1'b1;
            state_d     = StSend;
`else
            state_d = StFin;
`endif
          end else begin
            rdaddr_d = bus.start_addr;
            state_d  = StRd;
          end
        end
      end

      StRd: begin
        lat_d   = LatInit;
        state_d = StWaitq;
      end

      StWaitq: begin
        if (lat_q == 2'd0) begin
          data_d    = bus.ram_q;
          sum_d     = sum_q + bus.ram_q;
          send_en_d = 1'b1;
          state_d   = StSend;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      StSend: begin
        tmo_d   = '0;
        state_d = StWaitd;
`ifdef SUM_BYTE_EN
        if (!sum_phase_q) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
        end
`else
        addr_d = addr_q + AW'(1);
        rem_d  = rem_q - LW'(1);
`endif
      end

      StWaitd: begin
        // tx_done takes priority over a coincident timeout.
        if (bus.tx_done) begin
          if (rem_q != '0) begin
            rdaddr_d = addr_q;
            state_d  = StRd;
          end else begin
`ifdef SUM_BYTE_EN
            if (!sum_phase_q) begin
              data_d      = sum_q;
              sum_phase_d = 1'b1;
              send_en_d   = 1'b1;
              state_d     = StSend;
            end else begin
              state_d = StFin;
            end
`else
            state_d = StFin;
`endif
          end
        end else if (tmo_q >= TmoLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 17'd1;
        end
      end

      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      lat_q     <= '0;
      tmo_q     <= '0;
      sum_q     <= '0;
      rdaddr_q  <= '0;
      data_q    <= '0;
      send_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SUM_BYTE_EN
      sum_phase_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      lat_q     <= lat_d;
      tmo_q     <= tmo_d;
      sum_q     <= sum_d;
      rdaddr_q  <= rdaddr_d;
      data_q    <= data_d;
      send_en_q <= send_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef SUM_BYTE_EN
      sum_phase_q <= sum_phase_d;
`endif
    end
  end

  assign bus.ram_rdaddr = rdaddr_q;
  assign bus.data_byte  = data_q;
  assign bus.send_en    = send_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
